// File: rtl/ram_fifo_level.sv
// RAM-backed FIFO with fill level, almost-full/almost-empty hints, sticky
// overflow/underflow errors and a selectable registered or FWFT read port.
module ram_fifo_level #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = 2**ADDR_W - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              shift_in,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              shift_out,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned PW    = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    level_nxt;
  logic             rd_acc;
  logic             wr_acc;

  // Accept decisions use only registered flags; a full FIFO can take a write
  // when a read frees a slot in the same cycle, an empty one never passes through.
  always_comb begin
    rd_acc     = shift_out && !empty;
    wr_acc     = shift_in && (!full || rd_acc);
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr + PW'(rd_acc);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pointers, level, status flags and sticky errors; flags are registered from
  // the next pointer values so they line up with the pointers themselves.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_L);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      overflow     <= (overflow && !clr_err) || (shift_in && !wr_acc);
      underflow    <= (underflow && !clr_err) || (shift_out && empty);
    end
  end

  // Storage array; contents are not reset, and no write is taken during reset.
  always_ff @(posedge clk) begin
    if (!res && wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      // Registered read: head word lands on rdata on the accepting edge.
      always_ff @(posedge clk) begin
        if (res) begin
          rdata <= '0;
        end else if (rd_acc) begin
          rdata <= mem[rd_ptr[ADDR_W-1:0]];
        end
      end
    end else begin : g_fwft_read
      // First-word-fall-through: head word is always presented.
      assign rdata = mem[rd_ptr[ADDR_W-1:0]];
    end
  endgenerate

endmodule
